// File: rtl/kbd_pkg.sv
// Shared scancode constants, key map and FSM encoding
// for the PS/2 set-2 to CHIP-8 keypad translator.
package kbd_pkg;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BRK,
        ST_EXT,
        ST_EXT_BRK
    } kbd_state_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] key;
    } key_map_t;

    // Set-2 make code to CHIP-8 hex keypad index
    function automatic key_map_t map_scancode(input logic [7:0] sc);
        key_map_t m;
        m.valid = 1'b1;
        m.key   = 4'h0;
        case (sc)
            8'h16:   m.key = 4'h1;
            8'h1E:   m.key = 4'h2;
            8'h26:   m.key = 4'h3;
            8'h25:   m.key = 4'hC;
            8'h15:   m.key = 4'h4;
            8'h1D:   m.key = 4'h5;
            8'h24:   m.key = 4'h6;
            8'h2D:   m.key = 4'hD;
            8'h1C:   m.key = 4'h7;
            8'h1B:   m.key = 4'h8;
            8'h23:   m.key = 4'h9;
            8'h2B:   m.key = 4'hE;
            8'h1A:   m.key = 4'hA;
            8'h22:   m.key = 4'h0;
            8'h21:   m.key = 4'hB;
            8'h2A:   m.key = 4'hF;
            default: m.valid = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/sync_rise.sv
// Multi-flop synchroniser with rising-edge detect for
// slow asynchronous strobes.
module sync_rise #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_rise
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;
    logic [STAGES:0]   r_fill;

    // r_fill masks edges until r_prev holds a real post-reset
    // sample, so a strobe already high at release is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_fill <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_prev <= r_sync[STAGES-1];
            r_fill <= {r_fill[STAGES-1:0], 1'b1};
        end
    end

    assign o_rise = r_sync[STAGES-1] & ~r_prev & r_fill[STAGES];

endmodule

// File: rtl/kbd_matrix.sv
// PS/2 set-2 scancode stream to CHIP-8 16-key matrix,
// with press events and a registered any-key flag.
module kbd_matrix
    import kbd_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ps2_ready,
    input  logic [7:0]  ps2_data,
    input  logic        clear,
    output logic [15:0] key_matrix,
    output logic        key_event,
    output logic [3:0]  key_code,
    output logic        any_key
);

    logic        w_accept;
    key_map_t    w_map;
    logic        w_held;

    kbd_state_t  r_state;
    logic [15:0] r_matrix;
    logic        r_event;
    logic [3:0]  r_code;
    logic        r_any;

    sync_rise #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (ps2_ready),
        .o_rise  (w_accept)
    );

    assign w_map  = map_scancode(ps2_data);
    assign w_held = r_matrix[w_map.key];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_matrix <= '0;
            r_event  <= 1'b0;
            r_code   <= 4'h0;
            r_any    <= 1'b0;
        end else begin
            r_event <= 1'b0;
            r_any   <= |r_matrix;
            if (w_accept) begin
                unique case (r_state)
                    ST_IDLE: begin
                        if (ps2_data == SC_BREAK) begin
                            r_state <= ST_BRK;
                        end else if (ps2_data == SC_EXT) begin
                            r_state <= ST_EXT;
                        end else if (w_map.valid && !w_held
                                     && !clear) begin
                            r_matrix[w_map.key] <= 1'b1;
                            r_event             <= 1'b1;
                            r_code              <= w_map.key;
                        end
                    end
                    ST_BRK: begin
                        if (w_map.valid) begin
                            r_matrix[w_map.key] <= 1'b0;
                        end
                        r_state <= ST_IDLE;
                    end
                    ST_EXT: begin
                        if (ps2_data == SC_BREAK) begin
                            r_state <= ST_EXT_BRK;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_EXT_BRK: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
            // Placed last so a same-cycle make cannot survive clear
            if (clear) begin
                r_matrix <= '0;
            end
        end
    end

    assign key_matrix = r_matrix;
    assign key_event  = r_event;
    assign key_code   = r_code;
    assign any_key    = r_any;

endmodule

// File: tb/tb_kbd_matrix.sv
// Bench for kbd_matrix: directed table, hand sequences
// and random bytes against a prefix-queue model.
module tb_kbd_matrix;

    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ps2_ready = 1'b0;
    logic [7:0]  ps2_data = 8'h00;
    logic        clear = 1'b0;
    logic [15:0] key_matrix;
    logic        key_event;
    logic [3:0]  key_code;
    logic        any_key;

    int checks = 0;
    int failures = 0;
    int n_ev = 0;
    logic prev_ev = 1'b0;

    typedef struct {
        logic [7:0]  b;
        bit          clr;
        logic [15:0] m;
        bit          ev;
        logic [3:0]  code;
    } vec_t;

    vec_t vt[$];
    logic [15:0] last_m = 16'h0;

    logic [7:0] codes [16];
    int         keymap [256];
    logic [15:0] m_mat;
    logic [3:0]  m_code;
    logic [7:0]  m_pref[$];

    kbd_matrix #(.SYNC_STAGES(SYNC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2_ready  (ps2_ready),
        .ps2_data   (ps2_data),
        .clear      (clear),
        .key_matrix (key_matrix),
        .key_event  (key_event),
        .key_code   (key_code),
        .any_key    (any_key)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (key_event) begin
            n_ev++;
            chk("event_not_back_to_back", {31'd0, prev_ev}, 32'd0);
        end
        prev_ev = key_event;
    end

    task automatic send(input logic [7:0] b, input bit clr,
                        input logic [15:0] em, input bit eev,
                        input logic [3:0] ecode, input string tag);
        @(negedge clk);
        ps2_data  = b;
        ps2_ready = 1'b1;
        repeat (SYNC) @(posedge clk);
        @(negedge clk);
        clear = clr;
        chk({tag, " pre_matrix"}, {16'd0, key_matrix}, {16'd0, last_m});
        chk({tag, " pre_event"}, {31'd0, key_event}, 32'd0);
        @(negedge clk);
        clear = 1'b0;
        chk({tag, " matrix"}, {16'd0, key_matrix}, {16'd0, em});
        chk({tag, " event"}, {31'd0, key_event}, {31'd0, eev});
        chk({tag, " code"}, {28'd0, key_code}, {28'd0, ecode});
        chk({tag, " any_lag"}, {31'd0, any_key}, {31'd0, |last_m});
        @(negedge clk);
        chk({tag, " any"}, {31'd0, any_key}, {31'd0, |em});
        chk({tag, " event_off"}, {31'd0, key_event}, 32'd0);
        ps2_ready = 1'b0;
        repeat (SYNC + 2) @(negedge clk);
        last_m = em;
    endtask

    task automatic model_reset();
        m_mat  = 16'h0;
        m_code = 4'h0;
        m_pref.delete();
        last_m = 16'h0;
    endtask

    // Collect prefix bytes; act once a full code is complete
    task automatic model_byte(input logic [7:0] b, input bit clr,
                              output bit ev);
        int k;
        ev = 1'b0;
        k = keymap[b];
        if (m_pref.size() == 0 && (b == 8'hF0 || b == 8'hE0)) begin
            m_pref.push_back(b);
        end else if (m_pref.size() == 1 && m_pref[0] == 8'hE0
                     && b == 8'hF0) begin
            m_pref.push_back(b);
        end else begin
            if (m_pref.size() == 0) begin
                if (k >= 0 && !m_mat[k] && !clr) begin
                    m_mat[k] = 1'b1;
                    m_code   = 4'(k);
                    ev       = 1'b1;
                end
            end else if (m_pref[0] == 8'hF0) begin
                if (k >= 0) m_mat[k] = 1'b0;
            end
            m_pref.delete();
        end
        if (clr) m_mat = 16'h0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (SYNC + 3) @(negedge clk);
        model_reset();
    endtask

    initial begin
        int n0;
        bit ev;
        logic [7:0] b;
        bit clr;

        codes = '{8'h22, 8'h16, 8'h1E, 8'h26, 8'h15, 8'h1D, 8'h24,
                  8'h1C, 8'h1B, 8'h23, 8'h1A, 8'h21, 8'h25, 8'h2D,
                  8'h2B, 8'h2A};
        for (int i = 0; i < 256; i++) keymap[i] = -1;
        for (int k = 0; k < 16; k++) keymap[codes[k]] = k;

        vt.push_back('{8'h1E, 1'b0, 16'h0004, 1'b1, 4'h2});
        vt.push_back('{8'h1E, 1'b0, 16'h0004, 1'b0, 4'h2});
        vt.push_back('{8'h1E, 1'b0, 16'h0004, 1'b0, 4'h2});
        vt.push_back('{8'hF0, 1'b0, 16'h0004, 1'b0, 4'h2});
        vt.push_back('{8'h1E, 1'b0, 16'h0000, 1'b0, 4'h2});
        vt.push_back('{8'hE0, 1'b0, 16'h0000, 1'b0, 4'h2});
        vt.push_back('{8'h1E, 1'b0, 16'h0000, 1'b0, 4'h2});
        vt.push_back('{8'hE0, 1'b0, 16'h0000, 1'b0, 4'h2});
        vt.push_back('{8'hF0, 1'b0, 16'h0000, 1'b0, 4'h2});
        vt.push_back('{8'h1E, 1'b0, 16'h0000, 1'b0, 4'h2});
        vt.push_back('{8'h22, 1'b0, 16'h0001, 1'b1, 4'h0});
        vt.push_back('{8'h2A, 1'b0, 16'h8001, 1'b1, 4'hF});
        vt.push_back('{8'hF0, 1'b0, 16'h8001, 1'b0, 4'hF});
        vt.push_back('{8'h22, 1'b0, 16'h8000, 1'b0, 4'hF});
        vt.push_back('{8'h16, 1'b1, 16'h0000, 1'b0, 4'hF});
        vt.push_back('{8'h1E, 1'b0, 16'h0004, 1'b1, 4'h2});
        vt.push_back('{8'h77, 1'b0, 16'h0004, 1'b0, 4'h2});
        vt.push_back('{8'hF0, 1'b0, 16'h0004, 1'b0, 4'h2});
        vt.push_back('{8'h1E, 1'b0, 16'h0000, 1'b0, 4'h2});
        vt.push_back('{8'hF0, 1'b0, 16'h0000, 1'b0, 4'h2});
        vt.push_back('{8'h16, 1'b0, 16'h0000, 1'b0, 4'h2});

        repeat (3) @(negedge clk);
        chk("reset_matrix", {16'd0, key_matrix}, 32'd0);
        chk("reset_event", {31'd0, key_event}, 32'd0);
        chk("reset_code", {28'd0, key_code}, 32'd0);
        chk("reset_any", {31'd0, any_key}, 32'd0);
        rst_n = 1'b1;
        repeat (SYNC + 3) @(negedge clk);
        model_reset();

        for (int i = 0; i < vt.size(); i++) begin
            send(vt[i].b, vt[i].clr, vt[i].m, vt[i].ev, vt[i].code,
                 $sformatf("vec%0d", i));
        end

        // Reset after a break prefix discards it
        send(8'h16, 1'b0, 16'h0002, 1'b1, 4'h1, "pre_rst_make");
        send(8'hF0, 1'b0, 16'h0002, 1'b0, 4'h1, "pre_rst_f0");
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_matrix", {16'd0, key_matrix}, 32'd0);
        chk("async_rst_any", {31'd0, any_key}, 32'd0);
        chk("async_rst_code", {28'd0, key_code}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (SYNC + 3) @(negedge clk);
        model_reset();
        send(8'h1C, 1'b0, 16'h0080, 1'b1, 4'h7, "post_rst_1c");

        // Strobe already high when reset releases
        @(negedge clk);
        ps2_data  = 8'h1E;
        ps2_ready = 1'b1;
        rst_n     = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n0 = n_ev;
        repeat (10) @(negedge clk);
        chk("held_ready_matrix", {16'd0, key_matrix}, 32'd0);
        chk("held_ready_events", n_ev, n0);
        ps2_ready = 1'b0;
        repeat (SYNC + 2) @(negedge clk);
        model_reset();
        send(8'h1E, 1'b0, 16'h0004, 1'b1, 4'h2, "after_held");

        // Clear with no byte pending
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clear_only_matrix", {16'd0, key_matrix}, 32'd0);
        @(negedge clk);
        chk("clear_only_any", {31'd0, any_key}, 32'd0);

        do_reset();
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 9))
                6, 7:    b = 8'hF0;
                8:       b = 8'hE0;
                9:       b = 8'($urandom_range(0, 255));
                default: b = codes[$urandom_range(0, 15)];
            endcase
            clr = ($urandom_range(0, 9) == 0);
            model_byte(b, clr, ev);
            send(b, clr, m_mat, ev, m_code, $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
